// File: rtl/key_debounce_if.sv
// ============================================================================
// Module  : key_debounce_if
// Purpose : Raw key input and conditioned key outputs of the debounce stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_debounce_if;
    logic key_in;       // raw button, asynchronous, 0 = pressed
    logic key_level;    // debounced level, 0 = pressed
    logic key_press;
    logic key_release;
    logic key_long;

    // master: the button side driving key_in and consuming the results
    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    // slave: the debounce block itself
    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module  : key_debounce
// Purpose : Synchronise and debounce an active-low key; emit level and pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int LONG_CNT     = 50000000
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    key_debounce_if.slave  kif
);

    localparam int DB_W   = $clog2(DEBOUNCE_CNT) + 1;
    localparam int LONG_W = $clog2(LONG_CNT) + 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [LONG_W-1:0]   long_cnt_q, long_cnt_d;
    logic [LONG_W-1:0]   w_long_inc;
    logic                long_done_q, long_done_d;
    logic                key_level_q, key_level_d;
    logic                key_press_q, key_press_d;
    logic                key_release_q, key_release_d;
    logic                key_long_q, key_long_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= ST_IDLE;
            db_cnt_q      <= '0;
            long_cnt_q    <= '0;
            long_done_q   <= 1'b0;
            key_level_q   <= 1'b1;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_long_q    <= 1'b0;
        end else begin
            sync1_q       <= kif.key_in;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            db_cnt_q      <= db_cnt_d;
            long_cnt_q    <= long_cnt_d;
            long_done_q   <= long_done_d;
            key_level_q   <= key_level_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            key_long_q    <= key_long_d;
        end
    end

    // Saturating increment; key_long fires on the edge the count reaches its end
    assign w_long_inc = (long_cnt_q == LONG_LAST) ? long_cnt_q : long_cnt_q + LONG_W'(1);

    always_comb begin
        state_d       = state_q;
        db_cnt_d      = db_cnt_q;
        long_cnt_d    = long_cnt_q;
        long_done_d   = long_done_q;
        key_level_d   = key_level_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
        key_long_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!sync2_q) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = DB_W'(1);
                end
            end
            ST_PRESS_WAIT: begin
                if (sync2_q) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_PRESSED;
                    key_press_d = 1'b1;
                    key_level_d = 1'b0;
                    long_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            ST_PRESSED: begin
                long_cnt_d = w_long_inc;
                if (w_long_inc == LONG_LAST && !long_done_q) begin
                    key_long_d  = 1'b1;
                    long_done_d = 1'b1;
                end
                if (sync2_q) begin
                    state_d  = ST_RELEASE_WAIT;
                    db_cnt_d = DB_W'(1);
                end
            end
            ST_RELEASE_WAIT: begin
                if (!sync2_q) begin
                    state_d  = ST_PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d       = ST_IDLE;
                    key_release_d = 1'b1;
                    key_level_d   = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign kif.key_level   = key_level_q;
    assign kif.key_press   = key_press_q;
    assign kif.key_release = key_release_q;
    assign kif.key_long    = key_long_q;

endmodule

`default_nettype wire
